// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and single-cycle access sequencer for the data memory.
// Each granted request runs IDLE -> ACCESS -> DONE, with a one-cycle ack in DONE.
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_fun3,
    input  logic [7:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_fun3,
    input  logic [7:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_fun3,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state_reg;
    logic        ptr_reg;
    logic        slot_id_reg;
    logic        slot_we_reg;
    logic        slot_err_reg;
    logic [2:0]  slot_fun3_reg;
    logic [7:0]  slot_addr_reg;
    logic [31:0] slot_wdata_reg;
    logic [1:0][31:0] rdata_reg;

    logic [1:0]  req_vec;
    logic [1:0]  ack_vec;
    logic [1:0]  err_vec;
    logic        grant_id;
    logic        sel_we;
    logic [2:0]  sel_fun3;
    logic [7:0]  sel_addr;
    logic [31:0] sel_wdata;
    logic        access_ok;

    assign req_vec = {m1_req, m0_req};

    // Pointer only matters under contention; a lone requester always wins.
    assign grant_id  = (req_vec == 2'b11) ? ptr_reg : req_vec[1];
    assign sel_we    = grant_id ? m1_we    : m0_we;
    assign sel_fun3  = grant_id ? m1_fun3  : m0_fun3;
    assign sel_addr  = grant_id ? m1_addr  : m0_addr;
    assign sel_wdata = grant_id ? m1_wdata : m0_wdata;

    function automatic logic req_err(input logic we, input logic [2:0] fun3,
                                     input logic [7:0] addr);
        logic bad_code;
        logic overflow;
        if (we)
            bad_code = !(fun3 inside {3'b000, 3'b001, 3'b010});
        else
            bad_code = !(fun3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        overflow = ((fun3[1:0] == 2'b01) && (addr == 8'hFF)) ||
                   ((fun3[1:0] == 2'b10) && (addr >= 8'hFD));
        return bad_code || overflow;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= 1'b0;
            slot_id_reg    <= 1'b0;
            slot_we_reg    <= 1'b0;
            slot_err_reg   <= 1'b0;
            slot_fun3_reg  <= 3'b000;
            slot_addr_reg  <= 8'h00;
            slot_wdata_reg <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        slot_id_reg    <= grant_id;
                        slot_we_reg    <= sel_we;
                        slot_fun3_reg  <= sel_fun3;
                        slot_addr_reg  <= sel_addr;
                        slot_wdata_reg <= sel_wdata;
                        slot_err_reg   <= req_err(sel_we, sel_fun3, sel_addr);
                        state_reg      <= ACCESS;
                    end
                end
                ACCESS: state_reg <= DONE;
                DONE: begin
                    ptr_reg   <= ~slot_id_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign access_ok = (state_reg == ACCESS) && !slot_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (access_ok && !slot_we_reg) begin
            rdata_reg[slot_id_reg] <= mem_rdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign ack_vec[gi] = (state_reg == DONE) && (slot_id_reg == 1'(gi));
            assign err_vec[gi] = ack_vec[gi] && slot_err_reg;
        end
    endgenerate

    assign m0_ack   = ack_vec[0];
    assign m1_ack   = ack_vec[1];
    assign m0_err   = err_vec[0];
    assign m1_err   = err_vec[1];
    assign m0_rdata = rdata_reg[0];
    assign m1_rdata = rdata_reg[1];

    assign mem_read  = access_ok && !slot_we_reg;
    assign mem_write = access_ok && slot_we_reg;
    assign mem_fun3  = access_ok ? slot_fun3_reg  : 3'b000;
    assign mem_addr  = access_ok ? slot_addr_reg  : 8'h00;
    assign mem_wdata = access_ok ? slot_wdata_reg : 32'h0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-wide behavioural memory model.
module tb_dmem_arbiter;
    logic        clk;
    logic        rst;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [2:0]  m0_fun3, m1_fun3;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_fun3;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [256];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_fun3(m0_fun3), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_fun3(m1_fun3), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_fun3(mem_fun3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian memory; load extension is applied here, as the real memory does.
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_fun3[1:0] != 2'b00) mem[8'(mem_addr + 8'd1)] <= mem_wdata[15:8];
            if (mem_fun3[1:0] == 2'b10) begin
                mem[8'(mem_addr + 8'd2)] <= mem_wdata[23:16];
                mem[8'(mem_addr + 8'd3)] <= mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[mem_addr];
        b1 = mem[8'(mem_addr + 8'd1)];
        b2 = mem[8'(mem_addr + 8'd2)];
        b3 = mem[8'(mem_addr + 8'd3)];
        mem_rdata = 32'h0;
        case (mem_fun3)
            3'b000:  mem_rdata = {{24{b0[7]}}, b0};
            3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_rdata = {b3, b2, b1, b0};
            3'b100:  mem_rdata = {24'h0, b0};
            3'b101:  mem_rdata = {16'h0, b1, b0};
            default: mem_rdata = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with the FSM in IDLE; returns one negedge after the ack.
    task automatic do_req(input int port, input logic we, input logic [2:0] f,
                          input logic [7:0] a, input logic [31:0] wd,
                          output int lat, output logic e, output logic [31:0] rd,
                          output logic saw_mem);
        logic done;
        done = 1'b0; lat = 0; e = 1'bx; rd = 32'hx; saw_mem = 1'b0;
        if (port == 0) begin
            m0_we = we; m0_fun3 = f; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_fun3 = f; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
        end
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (mem_read || mem_write) saw_mem = 1'b1;
            if (port == 0 && m0_ack) begin done = 1'b1; e = m0_err; rd = m0_rdata; end
            if (port == 1 && m1_ack) begin done = 1'b1; e = m1_err; rd = m1_rdata; end
        end
        if (!done) lat = 99;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        $display("txn port=%0d we=%0d fun3=%b addr=%h wdata=%h lat=%0d err=%b rdata=%h",
                 port, we, f, a, wd, lat, e, rd);
    endtask

    initial begin
        int lat;
        logic e, sm;
        logic [31:0] rd;
        int n;
        int order [6];
        int tstamp [6];

        foreach (mem[i]) mem[i] = 8'h00;
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_fun3 = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_fun3 = 0; m1_addr = 0; m1_wdata = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_m0_ack", 32'(m0_ack), 32'd0);
        check("rst_m1_ack", 32'(m1_ack), 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_m1_rdata", m1_rdata, 32'h0);
        check("rst_mem_ctl", {27'd0, mem_read, mem_write, mem_fun3}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Store W then load W on port 0.
        do_req(0, 1'b1, 3'b010, 8'h10, 32'hDEADBEEF, lat, e, rd, sm);
        check("stw_lat", 32'(lat), 32'd2);
        check("stw_err", 32'(e), 32'd0);
        do_req(0, 1'b0, 3'b010, 8'h10, 32'h0, lat, e, rd, sm);
        check("ldw_lat", 32'(lat), 32'd2);
        check("ldw_err", 32'(e), 32'd0);
        check("ldw_rdata", rd, 32'hDEADBEEF);

        // Byte store, then signed and unsigned byte loads.
        do_req(0, 1'b1, 3'b000, 8'h01, 32'h12345689, lat, e, rd, sm);
        check("stb_err", 32'(e), 32'd0);
        check("stb_rdata_kept", rd, 32'hDEADBEEF);
        do_req(0, 1'b0, 3'b000, 8'h01, 32'h0, lat, e, rd, sm);
        check("ldb_rdata", rd, 32'hFFFFFF89);
        do_req(0, 1'b0, 3'b100, 8'h01, 32'h0, lat, e, rd, sm);
        check("ldbu_rdata", rd, 32'h00000089);

        // Word at 0x20 for the aborted half-store below.
        do_req(1, 1'b1, 3'b010, 8'h20, 32'hAABBCCDD, lat, e, rd, sm);
        check("stw20_err", 32'(e), 32'd0);

        // Reset during ACCESS of a half-store on port 0.
        m0_we = 1'b1; m0_fun3 = 3'b001; m0_addr = 8'h20; m0_wdata = 32'h00001234; m0_req = 1'b1;
        @(posedge clk);
        #1;
        check("sth_mem_write", {mem_write, mem_addr}, {1'b1, 8'h20});
        @(negedge clk);
        rst = 1'b1;
        m0_req = 1'b0;
        #1;
        check("rsta_mem_write", 32'(mem_write), 32'd0);
        check("rsta_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
        check("rsta_m0_rdata", m0_rdata, 32'h0);
        @(negedge clk);
        check("rsta_no_ack", 32'(m0_ack), 32'd0);
        rst = 1'b0;

        // Contention from reset: grants alternate 0,1,... starting at port 0.
        m0_we = 1'b0; m0_fun3 = 3'b010; m0_addr = 8'h10; m0_req = 1'b1;
        m1_we = 1'b0; m1_fun3 = 3'b010; m1_addr = 8'h20; m1_req = 1'b1;
        n = 0;
        foreach (order[i]) begin order[i] = -1; tstamp[i] = -100; end
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (m0_ack && m1_ack) check("both_ack", 32'd1, 32'd0);
            if (m0_ack) begin
                order[n] = 0; tstamp[n] = c;
                check("cont_m0_rdata", m0_rdata, 32'hDEADBEEF);
                $display("txn contention ack port=0 cycle=%0d rdata=%h", c, m0_rdata);
                n++;
            end else if (m1_ack) begin
                order[n] = 1; tstamp[n] = c;
                check("cont_m1_rdata", m1_rdata, 32'hAABBCCDD);
                $display("txn contention ack port=1 cycle=%0d rdata=%h", c, m1_rdata);
                n++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        check("cont_count", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("cont_order", 32'(order[i]), 32'(i % 2));
            if (i > 0) check("cont_spacing", 32'(tstamp[i] - tstamp[i-1]), 32'd3);
        end

        // Rejected requests: no memory cycle, rdata held.
        do_req(1, 1'b0, 3'b010, 8'hFE, 32'h0, lat, e, rd, sm);
        check("errw_lat", 32'(lat), 32'd2);
        check("errw_err", 32'(e), 32'd1);
        check("errw_nomem", 32'(sm), 32'd0);
        check("errw_rdata", rd, 32'hAABBCCDD);
        do_req(0, 1'b1, 3'b100, 8'h10, 32'h55555555, lat, e, rd, sm);
        check("errst_err", 32'(e), 32'd1);
        check("errst_nomem", 32'(sm), 32'd0);
        check("errst_rdata", rd, 32'hDEADBEEF);
        do_req(0, 1'b0, 3'b001, 8'hFF, 32'h0, lat, e, rd, sm);
        check("errh_err", 32'(e), 32'd1);
        do_req(0, 1'b0, 3'b010, 8'h10, 32'h0, lat, e, rd, sm);
        check("after_err_rdata", rd, 32'hDEADBEEF);
        check("after_err_err", 32'(e), 32'd0);

        // Reset during DONE kills the ack at once.
        m1_we = 1'b0; m1_fun3 = 3'b010; m1_addr = 8'h10; m1_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("done_ack_up", 32'(m1_ack), 32'd1);
        rst = 1'b1;
        m1_req = 1'b0;
        #1;
        check("rstd_ack", 32'(m1_ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
